// File: rtl/bitserial_logic8.sv
// ============================================================================
//  Module      : bitserial_logic8
//  Description : Bit-serial bitwise logic unit (OR/AND/XOR/NOT A), one result
//                bit per clock, LSB first, with a DONE pulse on completion.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bitserial_logic8 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] O,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH);

  // Each state bit maps directly onto one status output.
  localparam logic [1:0] C_ST_IDLE = 2'b00;
  localparam logic [1:0] C_ST_RUN  = 2'b01;
  localparam logic [1:0] C_ST_DONE = 2'b10;

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] C_OP_OR  = 2'b00;
  localparam logic [1:0] C_OP_AND = 2'b01;
  localparam logic [1:0] C_OP_XOR = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_s_q, a_s_d;
  logic [WIDTH-1:0] b_s_q, b_s_d;
  logic [1:0]       op_s_q, op_s_d;
  // Holds the WIDTH-1 bits already produced; the final bit completes the word.
  logic [WIDTH-2:0] part_q, part_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             z_q, z_d;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_bit;
  logic [WIDTH-1:0] w_word;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= C_ST_IDLE;
      cnt_q   <= '0;
      a_s_q   <= '0;
      b_s_q   <= '0;
      op_s_q  <= '0;
      part_q  <= '0;
      o_q     <= '0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_s_q   <= a_s_d;
      b_s_q   <= b_s_d;
      op_s_q  <= op_s_d;
      part_q  <= part_d;
      o_q     <= o_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    w_a_bit = a_s_q[cnt_q];
    w_b_bit = b_s_q[cnt_q];
    case (op_s_q)
      C_OP_OR:  w_bit = w_a_bit | w_b_bit;
      C_OP_AND: w_bit = w_a_bit & w_b_bit;
      C_OP_XOR: w_bit = w_a_bit ^ w_b_bit;
      default:  w_bit = ~w_a_bit;
    endcase
    w_word = {w_bit, part_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_s_d   = a_s_q;
    b_s_d   = b_s_q;
    op_s_d  = op_s_q;
    part_d  = part_q;
    o_d     = o_q;
    z_d     = z_q;
    case (state_q)
      C_ST_IDLE: begin
        if (START) begin
          a_s_d   = A;
          b_s_d   = B;
          op_s_d  = OP;
          part_d  = '0;
          cnt_d   = '0;
          state_d = C_ST_RUN;
        end
      end
      C_ST_RUN: begin
        part_d = w_word[WIDTH-1:1];
        if (cnt_q == C_LAST) begin
          o_d     = w_word;
          z_d     = (w_word == '0);
          state_d = C_ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      C_ST_DONE: begin
        state_d = C_ST_IDLE;
      end
      default: begin
        state_d = C_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    BUSY = (state_q == C_ST_RUN);
    DONE = (state_q == C_ST_DONE);
    O    = o_q;
    Z    = z_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_bitserial_logic8.sv
// ============================================================================
//  Module      : tb_bitserial_logic8
//  Description : Self-checking bench for bitserial_logic8 against a
//                cycle-count reference model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bitserial_logic8;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic [1:0]   OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] O;
  logic         Z;

  int           n_cmp = 0;
  int           n_err = 0;
  int           done_cnt = 0;

  // Model: cycles left in the current operation (0 = idle).
  int           m_t = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_o = '0;
  logic         m_z = 1'b1;

  always #5 CLK = ~CLK;

  bitserial_logic8 #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .O     (O),
    .Z     (Z)
  );

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check outputs just after.
  task automatic cyc(input logic r, input logic s, input logic [1:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    RST_N = r;
    START = s;
    OP    = op;
    A     = a;
    B     = b;
    @(posedge CLK);
    if (!r) begin
      m_t = 0;
      m_o = '0;
      m_z = 1'b1;
    end else if (m_t == 0) begin
      if (s) begin
        m_t   = W + 1;
        m_res = ref_op(op, a, b);
      end
    end else begin
      m_t--;
      if (m_t == 1) begin
        m_o = m_res;
        m_z = (m_res == '0);
      end
    end
    #1;
    if (DONE === 1'b1) done_cnt++;
    check("busy", {31'd0, BUSY}, {31'd0, (m_t >= 2)});
    check("done", {31'd0, DONE}, {31'd0, (m_t == 1)});
    check("o",    {24'd0, O},    {24'd0, m_o});
    check("z",    {31'd0, Z},    {31'd0, m_z});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'($urandom), W'($urandom), W'($urandom));
  endtask

  // Start one op, scramble A/B during RUN, then confirm the word against a constant.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_o, input string tag);
    cyc(1'b1, 1'b1, op, a, b);
    idle(W + 1);
    check(tag, {24'd0, O}, {24'd0, exp_o});
    check({tag, "_z"}, {31'd0, Z}, {31'd0, (exp_o == '0)});
  endtask

  initial begin
    // Reset held with START high: nothing may start.
    cyc(1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF);
    cyc(1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF);
    idle(2);

    // OR, then O must hold through a long idle stretch.
    run_op(2'b00, 8'hA0, 8'h0F, 8'hAF, "or");
    idle(20);
    check("or_hold", {24'd0, O}, 32'h0000_00AF);

    run_op(2'b01, 8'hCC, 8'hAA, 8'h88, "and");
    run_op(2'b10, 8'hCC, 8'hAA, 8'h66, "xor");
    run_op(2'b11, 8'hCC, 8'hAA, 8'h33, "not");
    run_op(2'b01, 8'hF0, 8'h0F, 8'h00, "and_zero");

    // START re-asserted with A=FF throughout RUN and DONE must be ignored.
    done_cnt = 0;
    cyc(1'b1, 1'b1, 2'b00, 8'h12, 8'h40);
    for (int i = 0; i < W + 1; i++) cyc(1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF);
    idle(W + 3);
    check("busy_prot_dones", done_cnt, 1);
    check("busy_prot_o", {24'd0, O}, 32'h0000_0052);

    // Abort mid-RUN, then a fresh op.
    done_cnt = 0;
    cyc(1'b1, 1'b1, 2'b10, 8'h5A, 8'hFF);
    idle(3);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    idle(12);
    check("abort_dones", done_cnt, 0);
    check("abort_o", {24'd0, O}, 32'd0);
    check("abort_z", {31'd0, Z}, 32'd1);
    run_op(2'b01, 8'h3C, 8'h0F, 8'h0C, "after_abort");

    // START held continuously: one op every WIDTH+2 cycles.
    done_cnt = 0;
    for (int i = 0; i < 3 * (W + 2); i++) cyc(1'b1, 1'b1, 2'($urandom), W'($urandom), W'($urandom));
    check("b2b_dones", done_cnt, 3);
    idle(2);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0), 2'($urandom),
          W'($urandom), W'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
